// File: rtl/rv32i_mem_decode.sv
// rv32i_mem_decode: instruction ROM, data RAM and combinational RV32I decoder
module rv32i_mem_decode #(
  parameter string ROM_INIT = "rom.hex",
  parameter string RAM_INIT = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  rom_addr,
  output logic [31:0] insn,
  input  logic        ram_wren,
  input  logic [6:0]  ram_addr,
  input  logic [31:0] ram_wdata,
  output logic [31:0] ram_rdata,
  output logic [4:0]  opcode,
  output logic [3:0]  alu_op,
  output logic [2:0]  bcu_op,
  output logic [2:0]  lsu_op,
  output logic        invalid,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm
);
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_MISC   = 5'b00011;
  localparam logic [4:0] OP_ALUIMM = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_ALU    = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;
  logic [31:0] rom [128];
  logic [31:0] ram [128];
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        bad;
  always_ff @(posedge clk) begin
    if (!rst) begin
      insn      <= '0;
      ram_rdata <= '0;
    end else begin
      insn      <= rom[rom_addr];
      ram_rdata <= ram[ram_addr];
      if (ram_wren) ram[ram_addr] <= ram_wdata;
    end
  end
  assign opcode = insn[6:2];
  assign f3     = insn[14:12];
  assign f7     = insn[31:25];
  assign rd     = insn[11:7];
  assign rs1    = insn[19:15];
  assign rs2    = insn[24:20];
  assign lsu_op = f3;
  always_comb begin
    alu_op = opcode == OP_ALU ? {insn[30], f3} :
             opcode == OP_ALUIMM ? {insn[30] & (f3 == 3'b101), f3} : 4'b0000;
    bcu_op = opcode == OP_BRANCH ? f3 :
             (opcode == OP_JAL || opcode == OP_JALR) ? 3'b011 : 3'b010;
    imm = {{20{insn[31]}}, insn[31:20]};
    bad = 1'b0;
    case (opcode)
      OP_LOAD:   bad = f3 == 3'b011 || f3[2:1] == 2'b11;
      OP_MISC, OP_SYSTEM: bad = 1'b0;
      OP_ALUIMM: bad = (f3 == 3'b001 && f7 != 7'h00) ||
                       (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
      OP_AUIPC, OP_LUI: imm = {insn[31:12], 12'b0};
      OP_STORE: begin
        imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
        bad = f3 > 3'b010;
      end
      OP_ALU:    bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      OP_BRANCH: begin
        imm = {{20{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
        bad = f3[2:1] == 2'b01;
      end
      OP_JALR:   bad = f3 != 3'b000;
      OP_JAL:    imm = {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
      default:   bad = 1'b1;
    endcase
    invalid = bad || insn[1:0] != 2'b11;
  end
endmodule

// File: tb/tb_rv32i_mem_decode.sv
// tb_rv32i_mem_decode: randomized check of ROM/RAM timing and decoder fields
// against an arithmetic reference model of the RV32I rules.
module tb_rv32i_mem_decode;
    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  rom_addr;
    logic [31:0] insn;
    logic        ram_wren;
    logic [6:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [4:0]  opcode;
    logic [3:0]  alu_op;
    logic [2:0]  bcu_op;
    logic [2:0]  lsu_op;
    logic        invalid;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] rom_m [128];
    logic [31:0] ram_m [128];
    bit          ram_v [128];

    typedef struct packed {
        logic [4:0]  op;
        logic [3:0]  alu;
        logic [2:0]  bcu;
        logic        inv;
        logic [31:0] imm;
    } dec_t;

    rv32i_mem_decode #(.ROM_INIT(""), .RAM_INIT("")) dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .insn(insn),
        .ram_wren(ram_wren), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .opcode(opcode), .alu_op(alu_op),
        .bcu_op(bcu_op), .lsu_op(lsu_op), .invalid(invalid), .rd(rd),
        .rs1(rs1), .rs2(rs2), .imm(imm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Immediates built by arithmetic shifting and masking rather than bit concatenation.
    function automatic dec_t model(input logic [31:0] i);
        dec_t d;
        int f3 = int'(i[14:12]);
        int f7 = int'(i[31:25]);
        logic [31:0] s20 = 32'($signed(i) >>> 20);
        d.op  = i[6:2];
        d.alu = 4'd0;
        if (d.op == 5'd12) d.alu = 4'(f3 + (i[30] ? 8 : 0));
        if (d.op == 5'd4)  d.alu = 4'(f3 + ((i[30] && f3 == 5) ? 8 : 0));
        d.bcu = d.op == 5'd24 ? 3'(f3) : (d.op == 5'd27 || d.op == 5'd25) ? 3'd3 : 3'd2;
        case (d.op)
            5'd8:  d.imm = (s20 & ~32'h1f) | 32'(i[11:7]);
            5'd24: d.imm = (32'($signed(i) >>> 19) & ~32'hfff) | (32'(i[7]) << 11)
                           | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            5'd5, 5'd13: d.imm = i & 32'hffff_f000;
            5'd27: d.imm = (32'($signed(i) >>> 11) & ~32'hfffff) | (32'(i[19:12]) << 12)
                           | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            default: d.imm = s20;
        endcase
        d.inv = i[1:0] != 2'b11 || !(d.op inside {5'd0, 5'd3, 5'd4, 5'd5, 5'd8, 5'd12,
                                                  5'd13, 5'd24, 5'd25, 5'd27, 5'd28});
        if (d.op == 5'd24 && !((8'b1111_0011 >> f3) & 8'd1)) d.inv = 1'b1;
        if (d.op == 5'd0  && !((8'b0011_0111 >> f3) & 8'd1)) d.inv = 1'b1;
        if (d.op == 5'd8  && f3 > 2) d.inv = 1'b1;
        if (d.op == 5'd25 && f3 != 0) d.inv = 1'b1;
        if (d.op == 5'd12 && !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)))) d.inv = 1'b1;
        if (d.op == 5'd4 && f3 == 1 && f7 != 0) d.inv = 1'b1;
        if (d.op == 5'd4 && f3 == 5 && f7 != 0 && f7 != 32) d.inv = 1'b1;
        return d;
    endfunction

    task automatic check_dec(input string tag);
        dec_t m = model(insn);
        chk({tag, ".opcode"}, 32'(opcode), 32'(m.op));
        chk({tag, ".alu_op"}, 32'(alu_op), 32'(m.alu));
        chk({tag, ".bcu_op"}, 32'(bcu_op), 32'(m.bcu));
        chk({tag, ".lsu_op"}, 32'(lsu_op), 32'(insn[14:12]));
        chk({tag, ".invalid"}, 32'(invalid), 32'(m.inv));
        chk({tag, ".rd"}, 32'(rd), 32'(insn[11:7]));
        chk({tag, ".rs1"}, 32'(rs1), 32'(insn[19:15]));
        chk({tag, ".rs2"}, 32'(rs2), 32'(insn[24:20]));
        chk({tag, ".imm"}, imm, m.imm);
    endtask

    task automatic fetch(input int a);
        rom_addr = 7'(a);
        @(posedge clk); #1;
        chk($sformatf("insn[%0d]", a), insn, rom_m[a]);
        check_dec($sformatf("dec[%0d]", a));
    endtask

    task automatic ram_op(input bit we, input int a, input logic [31:0] wd);
        ram_wren = we; ram_addr = 7'(a); ram_wdata = wd;
        @(posedge clk); #1;
        if (ram_v[a]) chk($sformatf("ram_rd[%0d]", a), ram_rdata, ram_m[a]);
        if (we) begin ram_m[a] = wd; ram_v[a] = 1'b1; end
        ram_wren = 1'b0;
    endtask

    function automatic logic [31:0] rand_insn();
        logic [4:0] ops [11] = '{5'd0, 5'd3, 5'd4, 5'd5, 5'd8, 5'd12, 5'd13, 5'd24, 5'd25, 5'd27, 5'd28};
        logic [31:0] w = $urandom;
        logic [6:0] f7s [3] = '{7'h00, 7'h20, 7'($urandom)};
        if ($urandom_range(0, 3) == 0) return w;
        w[6:0]   = {ops[$urandom_range(0, 10)], 2'b11};
        w[31:25] = f7s[$urandom_range(0, 2)];
        return w;
    endfunction

    initial begin
        logic [31:0] dir [8] = '{32'h0050_0093, 32'h4020_8133, 32'hFE00_0EE3, 32'h0080_00EF,
                                 32'h4010_D093, 32'h0000_000F, 32'h0000_3003, 32'h0010_0073};
        for (int i = 0; i < 128; i++) rom_m[i] = i < 8 ? dir[i] : rand_insn();
        for (int i = 0; i < 128; i++) dut.rom[i] = rom_m[i];
        rst = 1'b0; rom_addr = '0; ram_wren = 1'b0; ram_addr = '0; ram_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.insn", insn, 32'h0);
        chk("rst.ram_rdata", ram_rdata, 32'h0);
        chk("rst.invalid", 32'(invalid), 32'h1);
        chk("rst.opcode", 32'(opcode), 32'h0);
        rst = 1'b1;
        fetch(0);
        chk("addi.opcode", 32'(opcode), 32'h04);
        chk("addi.imm", imm, 32'h5);
        chk("addi.rd", 32'(rd), 32'h1);
        chk("addi.bcu", 32'(bcu_op), 32'h2);
        chk("addi.invalid", 32'(invalid), 32'h0);
        fetch(1); chk("sub.alu", 32'(alu_op), 32'h8);
        fetch(2); chk("beq.bcu", 32'(bcu_op), 32'h0); chk("beq.imm", imm, 32'hFFFF_FFFC);
        fetch(3); chk("jal.bcu", 32'(bcu_op), 32'h3); chk("jal.imm", imm, 32'h8);
        fetch(4); chk("srai.alu", 32'(alu_op), 32'hD); chk("srai.sh", 32'(imm[4:0]), 32'h1);
        fetch(5); chk("fence.invalid", 32'(invalid), 32'h0);
        fetch(6); chk("ld011.invalid", 32'(invalid), 32'h1);
        fetch(7); chk("ebreak.opcode", 32'(opcode), 32'h1C); chk("ebreak.imm", imm, 32'h1);
        for (int i = 0; i < 128; i++) fetch(i);
        repeat (200) fetch($urandom_range(0, 127));

        ram_op(1'b1, 6, 32'h1234_5678);
        ram_op(1'b1, 5, 32'h5555_AAAA);
        ram_op(1'b1, 5, 32'hDEAD_BEEF);
        ram_op(1'b0, 5, 32'h0);
        chk("ram.wr_rd5", ram_rdata, 32'hDEAD_BEEF);
        rst = 1'b0; ram_wren = 1'b1; ram_addr = 7'd6; ram_wdata = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        chk("ram.rst_rdata", ram_rdata, 32'h0);
        chk("ram.rst_insn", insn, 32'h0);
        rst = 1'b1; ram_wren = 1'b0;
        ram_op(1'b0, 6, 32'h0);
        chk("ram.rst_nowrite6", ram_rdata, 32'h1234_5678);
        repeat (400) ram_op(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
